// File: rtl/feature_map_streamer_pkg.sv
// Shared constants for the feature-map source streamer and its raster counter.
// Optional ZERO_PAD_BORDER_EN adds a one-pixel zero border around the frame.
package feature_map_streamer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned DEF_DATA_WIDHT = 32;
    localparam int unsigned DEF_CHANNELS   = 8;
    localparam int unsigned DEF_IMG_WIDHT  = 44;
    localparam int unsigned DEF_IMG_HEIGHT = 44;

    localparam int unsigned PIX_WIDTH    = DEF_DATA_WIDHT * DEF_CHANNELS;
    localparam int unsigned FRAME_PIXELS = DEF_IMG_WIDHT * DEF_IMG_HEIGHT;
    localparam int unsigned BORDER       = 1;

    function automatic int unsigned frame_beats(input int unsigned w, input int unsigned h);
`ifdef ZERO_PAD_BORDER_EN
        return (w + 2 * BORDER) * (h + 2 * BORDER);
`else
        return w * h;
`endif
    endfunction

endpackage

// File: rtl/feature_map_streamer_raster_counter.sv
// Row/column raster scanner with a running word address and last-pixel flag.
// The address advances only on positions flagged by addr_en_i, and wraps with the scan.
module raster_counter #(
    parameter int unsigned ROWS       = 44,
    parameter int unsigned COLS       = 44,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned RW         = $clog2(ROWS + 1),
    parameter int unsigned CW         = $clog2(COLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  addr_en_i,
    output logic [RW-1:0]         row_o,
    output logic [CW-1:0]         col_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last;

    assign last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (en_i) begin
            if (last) begin
                row_d  = '0;
                col_d  = '0;
                addr_d = '0;
            end else begin
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (addr_en_i) begin
                    addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign addr_o = addr_q;
    assign last_o = last;

endmodule

// File: rtl/feature_map_streamer.sv
// Source-end streamer: reads a stored feature map from sync RAM in raster order.
// Build option ZERO_PAD_BORDER_EN emits a one-pixel zero border without RAM reads.
module feature_map_streamer
    import feature_map_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDHT = DEF_DATA_WIDHT,
    parameter int unsigned CHANNELS   = DEF_CHANNELS,
    parameter int unsigned IMG_WIDHT  = DEF_IMG_WIDHT,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Start,
    input  logic                           Pause,
    output logic                           Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0]          Mem_Addr,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Mem_Data,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Busy,
    output logic                           Done
);

    localparam int unsigned PW = DATA_WIDHT * CHANNELS;
`ifdef ZERO_PAD_BORDER_EN
    localparam bit          PAD_EN = 1'b1;
    localparam int unsigned SCAN_W = IMG_WIDHT + 2 * BORDER;
    localparam int unsigned SCAN_H = IMG_HEIGHT + 2 * BORDER;
`else
    localparam bit          PAD_EN = 1'b0;
    localparam int unsigned SCAN_W = IMG_WIDHT;
    localparam int unsigned SCAN_H = IMG_HEIGHT;
`endif
    localparam int unsigned RW = $clog2(SCAN_H + 1);
    localparam int unsigned CW = $clog2(SCAN_W + 1);

    logic [1:0]            state_q, state_d;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] cnt_addr;
    logic                  last_pix;
    logic                  issue;
    logic                  border;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic                  v1_q, pad1_q;
    logic                  valid_q;
    logic [PW-1:0]         data_q;

    assign issue  = (state_q == ST_ISSUE) && !Pause;
    assign border = PAD_EN && ((row == '0) || (row == RW'(SCAN_H - 1)) ||
                               (col == '0) || (col == CW'(SCAN_W - 1)));
    assign rd_en  = issue && !border;

    raster_counter #(
        .ROWS       (SCAN_H),
        .COLS       (SCAN_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_raster_counter (
        .clk       (clk),
        .rst       (rst),
        .en_i      (issue),
        .addr_en_i (!border),
        .row_o     (row),
        .col_o     (col),
        .addr_o    (cnt_addr),
        .last_o    (last_pix)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_ISSUE;
            ST_ISSUE: if (issue && last_pix) state_d = ST_DRAIN;
            // Stage-2 beat still leaves this cycle, so Done lands right after it
            ST_DRAIN: if (!v1_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_hold_q <= '0;
            v1_q        <= 1'b0;
            pad1_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            if (rd_en) begin
                addr_hold_q <= cnt_addr;
            end
            v1_q    <= issue;
            pad1_q  <= issue && border;
            valid_q <= v1_q;
            if (v1_q) begin
                data_q <= pad1_q ? '0 : Mem_Data;
            end
        end
    end

    assign Mem_Rd_En = rd_en;
    assign Mem_Addr  = rd_en ? cnt_addr : addr_hold_q;
    assign Data_Out  = data_q;
    assign Valid_Out = valid_q;
    assign Busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_feature_map_streamer.sv
// Scoreboard bench for feature_map_streamer; handles ZERO_PAD_BORDER_EN builds too.
module tb_feature_map_streamer;
    import feature_map_streamer_pkg::*;

    localparam int W  = 44;
    localparam int H  = 44;
    localparam int AW = 11;
`ifdef ZERO_PAD_BORDER_EN
    localparam int BEATS = (W + 2) * (H + 2);
`else
    localparam int BEATS = W * H;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           Start = 1'b0;
    logic           Pause = 1'b0;
    logic           Mem_Rd_En;
    logic [AW-1:0]  Mem_Addr;
    logic [255:0]   Mem_Data = '0;
    logic [255:0]   Data_Out;
    logic           Valid_Out;
    logic           Busy;
    logic           Done;

    feature_map_streamer #(
        .DATA_WIDHT (32),
        .CHANNELS   (8),
        .IMG_WIDHT  (W),
        .IMG_HEIGHT (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Pause     (Pause),
        .Mem_Rd_En (Mem_Rd_En),
        .Mem_Addr  (Mem_Addr),
        .Mem_Data  (Mem_Data),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (Mem_Rd_En) Mem_Data <= {8{32'(Mem_Addr)}};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_word(input int b);
`ifdef ZERO_PAD_BORDER_EN
        int r, c;
        r = b / (W + 2);
        c = b % (W + 2);
        if (r == 0 || r == H + 1 || c == 0 || c == W + 1) return '0;
        return {8{32'((r - 1) * W + (c - 1))}};
`else
        return {8{32'(b)}};
`endif
    endfunction

    logic [255:0] exp_q[$];
    int           rd_q[$];
    int exp_addr = 0, frame_rd = 0, frame_beats = 0, done_count = 0;
    int start_cyc = 0, first_rd_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;

    always @(negedge clk) begin
        if (Mem_Rd_En) begin
            check("rd_addr", 256'(Mem_Addr), 256'(exp_addr));
            exp_addr++;
            frame_rd++;
            if (frame_rd == 1) first_rd_cyc = cyc;
            rd_q.push_back(cyc);
        end
        if (Valid_Out) begin
            if (exp_q.size() == 0) check("unexpected_valid", 256'(1), 256'(0));
            else check("data", Data_Out, exp_q.pop_front());
`ifndef ZERO_PAD_BORDER_EN
            if (rd_q.size() == 0) check("latency_no_read", 256'(1), 256'(0));
            else check("latency", 256'(cyc - rd_q.pop_front()), 256'(2));
`endif
            if (frame_beats == 0) first_beat_cyc = cyc;
            frame_beats++;
            last_beat_cyc = cyc;
        end
        if (Done) begin
            done_count++;
            check("done_lat", 256'(cyc), 256'(last_beat_cyc + 1));
            check("done_busy", 256'(Busy), 256'(0));
            check("beats", 256'(frame_beats), 256'(BEATS));
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        Start = 1'b1;
        start_cyc = cyc;
        exp_q.delete();
        rd_q.delete();
        for (int b = 0; b < BEATS; b++) exp_q.push_back(exp_word(b));
        exp_addr = 0;
        frame_rd = 0;
        frame_beats = 0;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        int t = 0;
        while (frame_rd < n && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_rd", 256'(frame_rd >= n), 256'(1));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!Done && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_seen", 256'(Done), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int dc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rd_en", 256'(Mem_Rd_En), 256'(0));
        check("rst_addr", 256'(Mem_Addr), 256'(0));
        check("rst_data", Data_Out, '0);
        check("rst_valid", 256'(Valid_Out), 256'(0));
        check("rst_busy", 256'(Busy), 256'(0));
        check("rst_done", 256'(Done), 256'(0));

        // Frame 1: latency, ignored Starts, 5-cycle pause, Start in DONE cycle
        start_frame();
        check("busy_after_start", 256'(Busy), 256'(1));
        wait_rd(10);
        pulse_start();
        wait_rd(100);
        Pause = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("pause_rd", 256'(Mem_Rd_En), 256'(0));
            @(posedge clk); #1;
        end
        Pause = 1'b0;
        wait_rd(500);
        pulse_start();
        wait_done();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("f1_idle_busy", 256'(Busy), 256'(0));
        check("f1_done_count", 256'(done_count), 256'(1));
        check("f1_rd_total", 256'(frame_rd), 256'(W * H));
        check("f1_q_empty", 256'(exp_q.size()), 256'(0));
        check("f1_first_beat", 256'(first_beat_cyc), 256'(start_cyc + 3));
        check("f1_span", 256'(last_beat_cyc - first_beat_cyc), 256'(BEATS - 1 + 5));
`ifndef ZERO_PAD_BORDER_EN
        check("f1_first_rd", 256'(first_rd_cyc), 256'(start_cyc + 1));
`endif

        // Frame 2: identical frame launched from IDLE
        start_frame();
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("f2_done_count", 256'(done_count), 256'(2));
        check("f2_rd_total", 256'(frame_rd), 256'(W * H));
        check("f2_span", 256'(last_beat_cyc - first_beat_cyc), 256'(BEATS - 1));

        // Frame 3: reset mid-frame
        start_frame();
        wait_rd(700);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        rd_q.delete();
        dc = done_count;
        check("abort_valid", 256'(Valid_Out), 256'(0));
        check("abort_busy", 256'(Busy), 256'(0));
        check("abort_rd_en", 256'(Mem_Rd_En), 256'(0));
        check("abort_data", Data_Out, '0);
        check("abort_done", 256'(Done), 256'(0));
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 256'(done_count), 256'(dc));
        check("abort_idle", 256'(Busy), 256'(0));

        // Frame 4: restart from address 0 after abort
        start_frame();
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("f4_done_count", 256'(done_count), 256'(dc + 1));
        check("f4_rd_total", 256'(frame_rd), 256'(W * H));
        check("f4_q_empty", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
